// File: rtl/conv_patch_feeder.sv
`default_nettype none
// ============================================================================
// Module  : conv_patch_feeder
// Purpose : Loads a 3x3 kernel serially, then turns a raster pixel stream into
//           sliding 3x3 windows (line-buffered) for the convolution MAC.
// Rev     : 1.0  initial release
// ============================================================================
module conv_patch_feeder #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wt_valid,
  input  logic [DATA_W-1:0] wt_data,
  output logic              wt_ready,
  output logic [DATA_W-1:0] weights_0,
  output logic [DATA_W-1:0] weights_1,
  output logic [DATA_W-1:0] weights_2,
  output logic [DATA_W-1:0] weights_3,
  output logic [DATA_W-1:0] weights_4,
  output logic [DATA_W-1:0] weights_5,
  output logic [DATA_W-1:0] weights_6,
  output logic [DATA_W-1:0] weights_7,
  output logic [DATA_W-1:0] weights_8,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] img_patch_0,
  output logic [DATA_W-1:0] img_patch_1,
  output logic [DATA_W-1:0] img_patch_2,
  output logic [DATA_W-1:0] img_patch_3,
  output logic [DATA_W-1:0] img_patch_4,
  output logic [DATA_W-1:0] img_patch_5,
  output logic [DATA_W-1:0] img_patch_6,
  output logic [DATA_W-1:0] img_patch_7,
  output logic [DATA_W-1:0] img_patch_8,
  output logic              frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] c_COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] c_ROW_TWO  = ROW_W'(2);
  localparam logic [3:0]       c_WT_LAST  = 4'd8;

  typedef enum logic [1:0] {
    WLOAD  = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic [3:0]        r_wt_cnt;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_weights [9];
  logic [DATA_W-1:0] r_win     [9];
  logic [DATA_W-1:0] r_patch   [9];
  logic [DATA_W-1:0] r_lb0     [IMG_W];
  logic [DATA_W-1:0] r_lb1     [IMG_W];
  logic [DATA_W-1:0] w_win_shift [9];

  logic w_pix_acc, w_last_col, w_last_pix, w_emit;

  assign w_pix_acc  = pix_valid && (r_state == STREAM) && (!r_out_valid || out_ready);
  assign w_last_col = (r_col == c_COL_LAST);
  assign w_last_pix = w_last_col && (r_row == c_ROW_LAST);
  assign w_emit     = w_pix_acc && (r_row >= c_ROW_TWO) && (r_col >= c_COL_TWO);

  // Window shifted left with the new column: two line-buffer rows above the incoming pixel.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_win_shift[3*r]   = r_win[3*r+1];
      w_win_shift[3*r+1] = r_win[3*r+2];
    end
    w_win_shift[2] = r_lb1[r_col];
    w_win_shift[5] = r_lb0[r_col];
    w_win_shift[8] = pix_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= WLOAD;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    wt_ready     = 1'b0;
    pix_ready    = 1'b0;
    frame_done   = 1'b0;
    case (r_state)
      WLOAD: begin
        wt_ready = 1'b1;
        if (wt_valid && (r_wt_cnt == c_WT_LAST)) w_state_next = STREAM;
      end
      STREAM: begin
        pix_ready = !r_out_valid || out_ready;
        if (w_pix_acc && w_last_pix) w_state_next = DONE;
      end
      DONE: begin
        frame_done   = 1'b1;
        w_state_next = STREAM;
      end
      default: w_state_next = WLOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wt_cnt    <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        r_weights[i] <= '0;
        r_win[i]     <= '0;
        r_patch[i]   <= '0;
      end
      for (int i = 0; i < IMG_W; i++) begin
        r_lb0[i] <= '0;
        r_lb1[i] <= '0;
      end
    end else begin
      if (r_state == WLOAD && wt_valid) begin
        r_weights[r_wt_cnt] <= wt_data;
        r_wt_cnt            <= (r_wt_cnt == c_WT_LAST) ? 4'd0 : r_wt_cnt + 4'd1;
      end
      if (w_pix_acc) begin
        for (int i = 0; i < 9; i++) r_win[i] <= w_win_shift[i];
        r_lb1[r_col] <= r_lb0[r_col];
        r_lb0[r_col] <= pix_data;
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_pix ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
      // A new window may replace one being transferred in the same cycle.
      if (w_emit) begin
        for (int i = 0; i < 9; i++) r_patch[i] <= w_win_shift[i];
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign weights_0   = r_weights[0];
  assign weights_1   = r_weights[1];
  assign weights_2   = r_weights[2];
  assign weights_3   = r_weights[3];
  assign weights_4   = r_weights[4];
  assign weights_5   = r_weights[5];
  assign weights_6   = r_weights[6];
  assign weights_7   = r_weights[7];
  assign weights_8   = r_weights[8];
  assign img_patch_0 = r_patch[0];
  assign img_patch_1 = r_patch[1];
  assign img_patch_2 = r_patch[2];
  assign img_patch_3 = r_patch[3];
  assign img_patch_4 = r_patch[4];
  assign img_patch_5 = r_patch[5];
  assign img_patch_6 = r_patch[6];
  assign img_patch_7 = r_patch[7];
  assign img_patch_8 = r_patch[8];

endmodule
`default_nettype wire

// File: tb/tb_conv_patch_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_conv_patch_feeder
// Purpose : Scoreboard bench for conv_patch_feeder (4x4 and 5x3 instances).
// Rev     : 1.0  initial release
// ============================================================================
module tb_conv_patch_feeder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wt_valid_a = 1'b0, wt_valid_b = 1'b0;
  logic [31:0] wt_data_a = '0, wt_data_b = '0;
  logic        wt_ready_a, wt_ready_b;
  logic [31:0] wts_a [9];
  logic [31:0] wts_b [9];
  logic        pix_valid_a = 1'b0, pix_valid_b = 1'b0;
  logic [31:0] pix_data_a = '0, pix_data_b = '0;
  logic        pix_ready_a, pix_ready_b;
  logic        out_valid_a, out_valid_b;
  logic        out_ready_a = 1'b1, out_ready_b = 1'b0;
  logic [31:0] patch_a [9];
  logic [31:0] patch_b [9];
  logic        frame_done_a, frame_done_b;

  conv_patch_feeder #(.IMG_W(4), .IMG_H(4), .DATA_W(32)) u_dut_a (
    .clk(clk), .reset(rst_n),
    .wt_valid(wt_valid_a), .wt_data(wt_data_a), .wt_ready(wt_ready_a),
    .weights_0(wts_a[0]), .weights_1(wts_a[1]), .weights_2(wts_a[2]),
    .weights_3(wts_a[3]), .weights_4(wts_a[4]), .weights_5(wts_a[5]),
    .weights_6(wts_a[6]), .weights_7(wts_a[7]), .weights_8(wts_a[8]),
    .pix_valid(pix_valid_a), .pix_data(pix_data_a), .pix_ready(pix_ready_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .img_patch_0(patch_a[0]), .img_patch_1(patch_a[1]), .img_patch_2(patch_a[2]),
    .img_patch_3(patch_a[3]), .img_patch_4(patch_a[4]), .img_patch_5(patch_a[5]),
    .img_patch_6(patch_a[6]), .img_patch_7(patch_a[7]), .img_patch_8(patch_a[8]),
    .frame_done(frame_done_a)
  );

  conv_patch_feeder #(.IMG_W(5), .IMG_H(3), .DATA_W(32)) u_dut_b (
    .clk(clk), .reset(rst_n),
    .wt_valid(wt_valid_b), .wt_data(wt_data_b), .wt_ready(wt_ready_b),
    .weights_0(wts_b[0]), .weights_1(wts_b[1]), .weights_2(wts_b[2]),
    .weights_3(wts_b[3]), .weights_4(wts_b[4]), .weights_5(wts_b[5]),
    .weights_6(wts_b[6]), .weights_7(wts_b[7]), .weights_8(wts_b[8]),
    .pix_valid(pix_valid_b), .pix_data(pix_data_b), .pix_ready(pix_ready_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .img_patch_0(patch_b[0]), .img_patch_1(patch_b[1]), .img_patch_2(patch_b[2]),
    .img_patch_3(patch_b[3]), .img_patch_4(patch_b[4]), .img_patch_5(patch_b[5]),
    .img_patch_6(patch_b[6]), .img_patch_7(patch_b[7]), .img_patch_8(patch_b[8]),
    .frame_done(frame_done_b)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int win_cnt_a = 0, fd_cnt_a = 0, fd_cnt_b = 0;
  logic rand_en = 1'b0;
  logic bp_done = 1'b0;
  logic [287:0] exp_a [$];
  logic [287:0] exp_b [$];
  logic [287:0] pack_a, pack_b;

  always_comb begin
    pack_a = '0;
    pack_b = '0;
    for (int k = 0; k < 9; k++) begin
      pack_a[k*32 +: 32] = patch_a[k];
      pack_b[k*32 +: 32] = patch_b[k];
    end
  end

  task automatic checkw(input string nm, input logic [287:0] act, input logic [287:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic checkb(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic checki(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Window whose top-left pixel index is tl in a row of width w; pixel value = base + index.
  function automatic logic [287:0] win(input int base, input int tl, input int w);
    logic [287:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[k*32 +: 32] = 32'(base + tl + w*(k/3) + k%3);
    return r;
  endfunction

  task automatic push_4x4(input int base);
    exp_a.push_back(win(base, 0, 4));
    exp_a.push_back(win(base, 1, 4));
    exp_a.push_back(win(base, 4, 4));
    exp_a.push_back(win(base, 5, 4));
  endtask

  // Scoreboard monitors: a transfer happens at the posedge after this sample.
  always @(negedge clk) begin
    if (out_valid_a && out_ready_a) begin
      if (exp_a.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL win_a_unexpected: got %h expected none", pack_a);
      end else begin
        checkw("win_a", pack_a, exp_a.pop_front());
      end
      win_cnt_a++;
    end
    if (out_valid_b && out_ready_b) begin
      if (exp_b.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL win_b_unexpected: got %h expected none", pack_b);
      end else begin
        checkw("win_b", pack_b, exp_b.pop_front());
      end
    end
    if (frame_done_a) fd_cnt_a++;
    if (frame_done_b) fd_cnt_b++;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_en) out_ready_b = 1'($urandom_range(0, 1));
    end
  end

  task automatic load_wt_a();
    for (int n = 0; n < 9; n++) begin
      wt_valid_a = 1'b1; wt_data_a = 32'h3F80_0000 + 32'(n);
      @(posedge clk); #1;
    end
    wt_valid_a = 1'b0;
  endtask

  task automatic load_wt_b();
    for (int n = 0; n < 9; n++) begin
      wt_valid_b = 1'b1; wt_data_b = 32'h4000_0000 + 32'(n);
      @(posedge clk); #1;
    end
    wt_valid_b = 1'b0;
  endtask

  task automatic send_pix_a(input logic [31:0] v);
    int t;
    t = 0;
    pix_valid_a = 1'b1; pix_data_a = v;
    @(negedge clk);
    while (!pix_ready_a && t < 200) begin @(negedge clk); t++; end
    if (!pix_ready_a) begin
      n_cmp++; n_fail++;
      $display("FAIL pix_a_timeout: pix_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    pix_valid_a = 1'b0;
  endtask

  task automatic send_pix_b(input logic [31:0] v);
    int t;
    t = 0;
    pix_valid_b = 1'b1; pix_data_b = v;
    @(negedge clk);
    while (!pix_ready_b && t < 200) begin @(negedge clk); t++; end
    if (!pix_ready_b) begin
      n_cmp++; n_fail++;
      $display("FAIL pix_b_timeout: pix_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    pix_valid_b = 1'b0;
  endtask

  task automatic drain_a();
    int t;
    t = 0;
    while ((exp_a.size() != 0 || out_valid_a) && t < 300) begin @(posedge clk); #1; t++; end
    checki("drain_a_pending", exp_a.size(), 0);
  endtask

  task automatic drain_b();
    int t;
    t = 0;
    while ((exp_b.size() != 0 || out_valid_b) && t < 300) begin @(posedge clk); #1; t++; end
    checki("drain_b_pending", exp_b.size(), 0);
  endtask

  initial begin
    int t, wc0, fd0;
    repeat (3) @(posedge clk);
    #1;
    checkb("rst_out_valid", out_valid_a, 1'b0);
    checkb("rst_wt_ready", wt_ready_a, 1'b1);
    checkb("rst_pix_ready", pix_ready_a, 1'b0);
    checkb("rst_frame_done", frame_done_a, 1'b0);
    checkw("rst_weights_0", {256'd0, wts_a[0]}, 288'd0);
    checkw("rst_patch", pack_a, 288'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Weight load, then stray weight words while streaming
    load_wt_a();
    checkb("wt_ready_after_load", wt_ready_a, 1'b0);
    checkb("pix_ready_after_load", pix_ready_a, 1'b1);
    for (int n = 0; n < 9; n++) checkw("weights", {256'd0, wts_a[n]}, {256'd0, 32'h3F80_0000 + 32'(n)});
    wt_valid_a = 1'b1; wt_data_a = 32'hDEAD_BEEF;
    repeat (3) begin @(posedge clk); #1; end
    wt_valid_a = 1'b0;
    checkw("weights_hold_0", {256'd0, wts_a[0]}, {256'd0, 32'h3F80_0000});
    checkw("weights_hold_8", {256'd0, wts_a[8]}, {256'd0, 32'h3F80_0008});

    // Window contents with latency and frame_done checks
    out_ready_a = 1'b1;
    push_4x4(0);
    for (int p = 0; p < 16; p++) begin
      send_pix_a(32'(p));
      if (p == 9)  checkb("latency_before_p10", out_valid_a, 1'b0);
      if (p == 10) checkb("latency_after_p10", out_valid_a, 1'b1);
      if (p == 15) checkb("frame_done_pulse", frame_done_a, 1'b1);
    end
    @(posedge clk); #1;
    checkb("frame_done_single", frame_done_a, 1'b0);
    drain_a();

    // Backpressure: first window held for 10 cycles
    out_ready_a = 1'b0;
    bp_done = 1'b0;
    push_4x4(32'h100);
    fork
      begin
        for (int p = 0; p < 16; p++) send_pix_a(32'h100 + 32'(p));
        bp_done = 1'b1;
      end
    join_none
    t = 0;
    @(negedge clk);
    while (!out_valid_a && t < 100) begin @(negedge clk); t++; end
    checkb("bp_out_valid", out_valid_a, 1'b1);
    for (int i = 0; i < 10; i++) begin
      checkb("bp_pix_ready", pix_ready_a, 1'b0);
      checkw("bp_patch_stable", pack_a, win(32'h100, 0, 4));
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready_a = 1'b1;
    t = 0;
    while (!bp_done && t < 300) begin @(posedge clk); #1; t++; end
    checkb("bp_stream_done", bp_done, 1'b1);
    drain_a();

    // Two back-to-back frames of identical data
    wc0 = win_cnt_a; fd0 = fd_cnt_a;
    push_4x4(0);
    push_4x4(0);
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < 16; p++) send_pix_a(32'(p));
    drain_a();
    repeat (2) begin @(posedge clk); #1; end
    checki("b2b_windows", win_cnt_a - wc0, 8);
    checki("b2b_frame_done", fd_cnt_a - fd0, 2);

    // Reset after pixel 7, reload, fresh frame
    for (int p = 0; p < 8; p++) send_pix_a(32'(p));
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkb("mid_rst_out_valid", out_valid_a, 1'b0);
    checkb("mid_rst_wt_ready", wt_ready_a, 1'b1);
    checkw("mid_rst_weights_0", {256'd0, wts_a[0]}, 288'd0);
    checkw("mid_rst_weights_8", {256'd0, wts_a[8]}, 288'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_wt_a();
    checkw("reload_weights_4", {256'd0, wts_a[4]}, {256'd0, 32'h3F80_0004});
    push_4x4(0);
    for (int p = 0; p < 16; p++) send_pix_a(32'(p));
    drain_a();

    // 5x3 frame with random pixel gaps and random downstream ready
    load_wt_b();
    checkw("b_weights_8", {256'd0, wts_b[8]}, {256'd0, 32'h4000_0008});
    exp_b.push_back(win(32'h200, 0, 5));
    exp_b.push_back(win(32'h200, 1, 5));
    exp_b.push_back(win(32'h200, 2, 5));
    rand_en = 1'b1;
    for (int p = 0; p < 15; p++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      send_pix_b(32'h200 + 32'(p));
    end
    drain_b();
    rand_en = 1'b0;
    out_ready_b = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checki("b_frame_done", fd_cnt_b, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
